// File: rtl/flight_pkg.sv
// flight_pkg: phase encoding and fixed-point altitude constants (km x 1e9)
package flight_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, AIR = 2'd1, NOAIR = 2'd2, REPORT = 2'd3} phase_t;
  localparam logic [63:0] FX_SCALE = 64'd1_000_000_000;
  localparam logic [63:0] KM100 = 64'd100 * FX_SCALE;
  localparam logic [63:0] KM188 = 64'd188 * FX_SCALE;
endpackage

// File: rtl/threshold_debounce.sv
// threshold_debounce: pulses hit on the DEBOUNCE-th consecutive valid sample at or above TH
module threshold_debounce #(
  parameter int N = 64,
  parameter logic [N-1:0] TH = '0,
  parameter int DEBOUNCE = 3
) (
  input  logic         clk,
  input  logic         resetb,
  input  logic         clr,
  input  logic         valid,
  input  logic [N-1:0] value,
  output logic         hit
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  logic [CW-1:0] cnt;
  logic qual;
  assign qual = valid && (value >= TH);
  assign hit = !clr && qual && (cnt == CW'(DEBOUNCE - 1));
  // invalid cycles hold the count; a non-qualifying valid sample breaks the run
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) cnt <= '0;
    else if (clr || hit || (valid && !qual)) cnt <= '0;
    else if (qual) cnt <= cnt + CW'(1);
endmodule

// File: rtl/flight_phase_ctrl.sv
// flight_phase_ctrl: debounced IDLE/AIR/NOAIR/REPORT phase tracker driving sticky
// noair_altitude and print188km for the downstream altitude stage
module flight_phase_ctrl
  import flight_pkg::*;
#(
  parameter int N = 64,
  parameter logic [N-1:0] NOAIR_H = KM100,
  parameter logic [N-1:0] REPORT_H = KM188,
  parameter int DEBOUNCE = 3
) (
  input  logic         clk,
  input  logic         resetb,
  input  logic         launch,
  input  logic         height_valid,
  input  logic [N-1:0] height,
  output logic [N-1:0] noair_altitude,
  output logic         print188km,
  output logic [1:0]   phase,
  output logic         phase_evt
);
  phase_t state, nxt;
  logic [N-1:0] na_nxt;
  logic pr_nxt, evt_nxt, hit_na, hit_rp;

  // each counter only runs in its own phase, so it starts from zero on entry
  threshold_debounce #(.N(N), .TH(NOAIR_H), .DEBOUNCE(DEBOUNCE)) u_noair (
    .clk(clk), .resetb(resetb), .clr(launch || state != AIR),
    .valid(height_valid), .value(height), .hit(hit_na)
  );
  threshold_debounce #(.N(N), .TH(REPORT_H), .DEBOUNCE(DEBOUNCE)) u_report (
    .clk(clk), .resetb(resetb), .clr(launch || state != NOAIR),
    .valid(height_valid), .value(height), .hit(hit_rp)
  );

  always_comb begin
    nxt = launch ? AIR : hit_na ? NOAIR : hit_rp ? REPORT : state;
    na_nxt = launch ? '0 : hit_na ? height : noair_altitude;
    pr_nxt = launch ? 1'b0 : hit_rp ? 1'b1 : print188km;
    evt_nxt = nxt != state;
  end

  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      state <= IDLE;
      noair_altitude <= '0;
      print188km <= 1'b0;
      phase_evt <= 1'b0;
    end else begin
      state <= nxt;
      noair_altitude <= na_nxt;
      print188km <= pr_nxt;
      phase_evt <= evt_nxt;
    end

  assign phase = state;
endmodule
